// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART<->ALU sequencer.
// State encoding, default data width and the ALU opcode map.
package alu_uart_pkg;

    localparam int DBIT_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_B  = 3'd1,
        S_GET_OP = 3'd2,
        S_EXEC   = 3'd3,
        S_SEND   = 3'd4
    } seq_state_t;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_NOR = 8'h27;

    // True when the opcode belongs to the ALU's supported set.
    function automatic logic op_is_known(input logic [7:0] opc);
        logic known;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: known = 1'b1;
            default:                        known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_uart_sequencer.sv
// UART<->ALU sequencer: pops operand A, operand B and opcode from the RX FIFO, waits ALU_LAT
// cycles, then pushes the ALU result into the TX FIFO. Inter-byte timeout built with ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
    import alu_uart_pkg::*;
#(
    parameter int DBIT      = DBIT_DEFAULT,
    parameter int ALU_LAT   = 1,
    parameter int TO_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] a,
    output logic [DBIT-1:0] b,
    output logic [DBIT-1:0] op,
    input  logic [DBIT-1:0] w,
    output logic            busy,
    output logic            done,
    output logic            err
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [DBIT-1:0] r_a;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_op;
    logic [DBIT-1:0] r_w_data;
    logic [3:0]      r_lat_cnt;
    logic            w_lat_done;
    logic            w_to_hit;
    logic            w_rd;
    logic            w_wr;
    logic            w_err;

    assign w_lat_done = (r_lat_cnt == 4'(ALU_LAT - 1));

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES) + 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            w_rx_wait;

    assign w_rx_wait = (r_state == S_GET_B) || (r_state == S_GET_OP);
    assign w_to_hit  = w_rx_wait && rx_empty && (r_to_cnt == TO_W'(TO_CYCLES - 1));

    // Mid-frame idle counter; any pop or state exit clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (w_rx_wait && rx_empty && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            r_to_cnt <= {TO_W{1'b0}};
        end
    end
`else
    // No timeout in this build: the FSM waits indefinitely for the next byte.
    assign w_to_hit = (TO_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_GET_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_GET_A: begin
                if (!rx_empty) w_state_nxt = S_GET_B;
                else           w_state_nxt = S_GET_A;
            end
            S_GET_B: begin
                if (!rx_empty)    w_state_nxt = S_GET_OP;
                else if (w_to_hit) w_state_nxt = S_GET_A;
                else              w_state_nxt = S_GET_B;
            end
            S_GET_OP: begin
                if (!rx_empty)    w_state_nxt = S_EXEC;
                else if (w_to_hit) w_state_nxt = S_GET_A;
                else              w_state_nxt = S_GET_OP;
            end
            S_EXEC: begin
                if (w_lat_done) w_state_nxt = S_SEND;
                else            w_state_nxt = S_EXEC;
            end
            S_SEND: begin
                if (!tx_full) w_state_nxt = S_GET_A;
                else          w_state_nxt = S_SEND;
            end
            default: w_state_nxt = S_GET_A;
        endcase
    end

    // FIFO strobes; pops/pushes must land in the same cycle the FIFO flags allow them.
    always_comb begin
        w_rd  = 1'b0;
        w_wr  = 1'b0;
        w_err = 1'b0;
        if (!reset) begin
            w_rd  = 1'b0;
            w_wr  = 1'b0;
            w_err = 1'b0;
        end else begin
            case (r_state)
                S_GET_A, S_GET_B, S_GET_OP: begin
                    w_rd  = !rx_empty;
                    w_err = w_to_hit;
                end
                S_SEND:  w_wr = !tx_full;
                S_EXEC:  w_rd = 1'b0;
                default: w_rd = 1'b0;
            endcase
        end
    end

    // Operand capture, latency count and result latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a       <= {DBIT{1'b0}};
            r_b       <= {DBIT{1'b0}};
            r_op      <= {DBIT{1'b0}};
            r_w_data  <= {DBIT{1'b0}};
            r_lat_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_GET_A: begin
                    if (w_rd) r_a <= r_data;
                end
                S_GET_B: begin
                    if (w_rd) r_b <= r_data;
                end
                S_GET_OP: begin
                    if (w_rd) r_op <= r_data;
                    r_lat_cnt <= 4'd0;
                end
                S_EXEC: begin
                    if (w_lat_done) r_w_data  <= w;
                    else            r_lat_cnt <= r_lat_cnt + 4'd1;
                end
                default: r_lat_cnt <= r_lat_cnt;
            endcase
        end
    end

    assign rd_uart = w_rd;
    assign wr_uart = w_wr;
    assign done    = w_wr;
    assign err     = w_err;
    assign busy    = (r_state != S_GET_A);
    assign a       = r_a;
    assign b       = r_b;
    assign op      = r_op;
    assign w_data  = r_w_data;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer: directed scenarios plus randomized frames against
// a queue-based FIFO/ALU reference model. Timeout scenario depends on ALU_SEQ_TIMEOUT_EN.
module tb_alu_uart_sequencer;
    import alu_uart_pkg::*;

    localparam int DBIT = 8;
    localparam int LAT  = 3;
    localparam int TO   = 100;
    localparam int NRND = 40;

    logic            clk      = 1'b0;
    logic            reset    = 1'b0;
    logic            rx_empty = 1'b1;
    logic            tx_full  = 1'b0;
    logic [DBIT-1:0] r_data   = 8'h00;
    logic [DBIT-1:0] w        = 8'h00;
    logic            rd_uart, wr_uart, busy, done, err;
    logic [DBIT-1:0] w_data, a, b, op;

    alu_uart_sequencer #(.DBIT(DBIT), .ALU_LAT(LAT), .TO_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .a(a), .b(b), .op(op),
        .w(w), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, n_err = 0, viol = 0;
    int last_rd_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;
    int stable = 100;
    logic [23:0]     prev_ops = 24'h0;
    logic [DBIT-1:0] rx_q[$];
    logic [DBIT-1:0] tx_got[$];
    logic [DBIT-1:0] exp_q[$];
    logic [DBIT-1:0] ops[8];

    function automatic logic [7:0] alu_ref(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SRA:  return 8'($signed(x) >>> y[2:0]);
            OP_SRL:  return x >> y[2:0];
            OP_NOR:  return ~(x | y);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ALU model: result only settles after operands have been stable LAT cycles.
    task automatic drive_inputs();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
        w        = (stable >= LAT) ? alu_ref(a, b, op) : ~alu_ref(a, b, op);
    endtask

    task automatic push_byte(input logic [7:0] v);
        rx_q.push_back(v);
        drive_inputs();
    endtask

    task automatic tick();
        logic pop;
        @(negedge clk);
        cyc++;
        pop = rd_uart;
        if (rd_uart) begin n_rd++; last_rd_cyc = cyc; end
        if (wr_uart) begin n_wr++; last_wr_cyc = cyc; tx_got.push_back(w_data); end
        if (err)     begin n_err++; last_err_cyc = cyc; end
        if ((rd_uart && rx_empty) || (rd_uart && wr_uart) || (done != wr_uart) || (wr_uart && tx_full))
            viol++;
        @(posedge clk);
        #1;
        if (pop && rx_q.size() > 0) rx_q.delete(0);
        if ({a, b, op} != prev_ops) begin
            prev_ops = {a, b, op};
            stable   = 1;
        end else if (stable < 100) begin
            stable++;
        end
        drive_inputs();
    endtask

    task automatic rand_tick();
        tx_full = ($urandom_range(0, 3) == 0);
        tick();
    endtask

    task automatic run_until_write(input string tag, input int budget);
        int start;
        start = n_wr;
        for (int i = 0; i < budget && n_wr == start; i++) tick();
        check_eq(tag, (n_wr > start) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int base_rd, base_wr, base_err, hold_bad, pop_cyc, start_idx;
        logic [7:0] x, y, o;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

        // 1: reset held with data waiting
        reset = 1'b0;
        push_byte(8'hAA);
        repeat (5) tick();
        check_eq("rst_no_pop", n_rd, 0);
        check_eq("rst_regs", {a, b, op, w_data}, 32'h0);
        check_eq("rst_flags", {rd_uart, wr_uart, done, err, busy}, 32'h0);
        rx_q.delete();
        drive_inputs();
        reset = 1'b1;
        tick();
        check_eq("idle_busy", busy, 0);

        // 2: back-to-back ADD frame
        base_rd = n_rd;
        push_byte(8'h01); push_byte(8'h03); push_byte(OP_ADD);
        run_until_write("t2_write_seen", 30);
        check_eq("t2_result", tx_got[tx_got.size()-1], 8'h04);
        check_eq("t2_operands", {a, b, op}, 24'h010320);
        check_eq("t2_pops", n_rd - base_rd, 3);
        check_eq("t2_latency", last_wr_cyc - last_rd_cyc, LAT + 1);
        check_eq("t2_idle_busy", busy, 0);

        // 3: widely spaced bytes, SUB
        base_rd = n_rd; base_wr = n_wr; base_err = n_err;
        push_byte(8'h05); repeat (52) tick();
        push_byte(8'h07); repeat (52) tick();
        push_byte(OP_SUB);
        run_until_write("t3_write_seen", 30);
        repeat (10) tick();
        check_eq("t3_pops", n_rd - base_rd, 3);
        check_eq("t3_writes", n_wr - base_wr, 1);
        check_eq("t3_result", tx_got[tx_got.size()-1], 8'hFE);
        check_eq("t3_no_err", n_err - base_err, 0);

        // 4: TX back-pressure at the send stage
        tx_full = 1'b1;
        base_wr = n_wr; hold_bad = 0;
        push_byte(8'hF0); push_byte(8'h3C); push_byte(OP_OR);
        repeat (3 + LAT) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_data != 8'hFC) hold_bad++;
        end
        check_eq("t4_no_write", n_wr - base_wr, 0);
        check_eq("t4_hold", hold_bad, 0);
        check_eq("t4_busy", busy, 1);
        tx_full = 1'b0;
        tick();
        check_eq("t4_write_now", n_wr - base_wr, 1);
        check_eq("t4_result", tx_got[tx_got.size()-1], 8'hFC);

        // 5: reset in the middle of a frame
        base_rd = n_rd;
        push_byte(8'h11); push_byte(8'h22);
        repeat (2) tick();
        check_eq("t5_two_pops", n_rd - base_rd, 2);
        reset = 1'b0;
        repeat (2) tick();
        check_eq("t5_cleared", {a, b, op, 7'h0, busy}, 32'h0);
        reset = 1'b1;
        base_wr = n_wr;
        push_byte(8'h02); push_byte(8'h02); push_byte(OP_ADD);
        run_until_write("t5_write_seen", 30);
        repeat (10) tick();
        check_eq("t5_writes", n_wr - base_wr, 1);
        check_eq("t5_result", tx_got[tx_got.size()-1], 8'h04);

        // 6: one byte then silence
        base_wr = n_wr; base_err = n_err;
        push_byte(8'h33);
        tick();
        pop_cyc = last_rd_cyc;
`ifdef ALU_SEQ_TIMEOUT_EN
        for (int i = 0; i < 2 * TO && n_err == base_err; i++) tick();
        check_eq("t6_err_once", n_err - base_err, 1);
        check_eq("t6_err_cycle", last_err_cyc - pop_cyc, TO);
        check_eq("t6_no_write", n_wr - base_wr, 0);
        check_eq("t6_a_kept", a, 8'h33);
        check_eq("t6_idle", busy, 0);
        push_byte(8'h04); push_byte(8'h09); push_byte(OP_XOR);
        run_until_write("t6_next_write", 30);
        check_eq("t6_next_result", tx_got[tx_got.size()-1], 8'h0D);
`else
        repeat (150) tick();
        check_eq("t6_no_err", n_err - base_err, 0);
        check_eq("t6_still_waiting", busy, 1);
        check_eq("t6_no_write", n_wr - base_wr, 0);
        push_byte(8'h44); push_byte(OP_ADD);
        run_until_write("t6_resume_write", 30);
        check_eq("t6_resume_result", tx_got[tx_got.size()-1], 8'h77);
`endif

        // Randomized frames with random gaps and random TX back-pressure
        start_idx = tx_got.size();
        for (int f = 0; f < NRND; f++) begin
            x = 8'($urandom); y = 8'($urandom); o = ops[$urandom_range(0, 7)];
            exp_q.push_back(alu_ref(x, y, o));
            repeat ($urandom_range(0, 3)) rand_tick();
            push_byte(x);
            repeat ($urandom_range(0, 3)) rand_tick();
            push_byte(y);
            repeat ($urandom_range(0, 3)) rand_tick();
            push_byte(o);
        end
        for (int i = 0; i < 3000 && (tx_got.size() - start_idx) < NRND; i++) rand_tick();
        tx_full = 1'b0;
        repeat (10) tick();
        check_eq("rnd_count", tx_got.size() - start_idx, NRND);
        for (int i = 0; i < NRND && (start_idx + i) < tx_got.size(); i++)
            check_eq($sformatf("rnd_result_%0d", i), tx_got[start_idx + i], exp_q[i]);

        check_eq("protocol_violations", viol, 0);
`ifdef ALU_SEQ_TIMEOUT_EN
        check_eq("total_err", n_err, 1);
`else
        check_eq("total_err", n_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
